// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables, self-clearing INIT sweep and collision flag.
// Define SP_RAM_PARITY_EN to store one even-parity bit per byte and report read mismatches.
module sp_ram_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] be,
  input  logic                par_inj,
  output logic [DATA_W-1:0]   d_out,
  output logic                d_valid,
  output logic                ready,
  output logic                err,
  output logic                par_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StInit, StIdle} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_init;
  logic              rd_go;
  logic              wr_go;
  logic              coll;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    in_init   = (state_q == StInit);
    rd_go     = !in_init && cs && rd && !wr;
    wr_go     = !in_init && cs && wr && !rd;
    coll      = !in_init && cs && rd && wr;
    // The clear sweep owns the write port while in INIT.
    mem_we    = in_init || wr_go;
    mem_addr  = in_init ? cnt_q : addr;
    mem_be    = in_init ? '1 : be;
    mem_wdata = in_init ? '0 : data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ready   <= 1'b0;
      d_out   <= '0;
      d_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      d_valid <= rd_go;
      err     <= coll;
      if (rd_go) d_out <= mem[addr];
      unique case (state_q)
        StInit: begin
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        StIdle: ready <= 1'b1;
        default: state_q <= StInit;
      endcase
    end
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par;
  logic          inj;

  assign inj = wr_go && par_inj;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) par_mem[mem_addr][i] <= (^mem_wdata[8*i +: 8]) ^ inj;
      end
    end
  end

  always_comb begin
    rd_par = '0;
    for (int unsigned i = 0; i < NB; i++) rd_par[i] = ^mem[addr][8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= rd_go && |(rd_par ^ par_mem[addr]);
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed self-checking bench for sp_ram_be (DATA_W=32, ADDR_W=4).
module tb_sp_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, rd, wr, par_inj;
  logic [3:0]  addr;
  logic [31:0] data;
  logic [3:0]  be;
  logic [31:0] d_out;
  logic        d_valid, ready, err, par_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sp_ram_be #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .data(data),
    .be(be), .par_inj(par_inj), .d_out(d_out), .d_valid(d_valid), .ready(ready),
    .err(err), .par_err(par_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cs = 0; rd = 0; wr = 0; par_inj = 0; be = 4'h0; data = '0; addr = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b,
                          input logic inj);
    cs = 1; wr = 1; rd = 0; addr = a; data = d; be = b; par_inj = inj;
    tick();
    set_idle();
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] q, output logic v,
                         output logic pe);
    cs = 1; rd = 1; wr = 0; addr = a;
    tick();
    q = d_out; v = d_valid; pe = par_err;
    set_idle();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    set_idle();
    rst = 1;
    #1;
    n_checks++;
    if (d_out !== 32'h0 || d_valid !== 1'b0 || ready !== 1'b0 || err !== 1'b0 ||
        par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: d_out=%h d_valid=%b ready=%b err=%b par_err=%b, want all 0",
               d_out, d_valid, ready, err, par_err);
    end
    tick(); tick();
    rst = 0;
    wait_ready(n);
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL init_length: ready after %0d cycles, want 16", n);
    end
  endtask

  task automatic test_read_all();
    logic [31:0] q; logic v, pe;
    for (int a = 0; a < 16; a++) begin
      do_read(a[3:0], q, v, pe);
      n_checks++;
      if (q !== 32'h0 || v !== 1'b1) begin
        n_fail++;
        $display("FAIL read_cleared[%0d]: d_out=%h d_valid=%b, want 00000000 1", a, q, v);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] q; logic v, pe;
    do_write(4'd3, 32'hDEADBEEF, 4'hF, 1'b0);
    do_write(4'd3, 32'h11223344, 4'b0101, 1'b0);
    do_write(4'd3, 32'h99999999, 4'h0, 1'b0);
    n_checks++;
    if (err !== 1'b0 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL be_zero_flags: err=%b d_valid=%b, want 0 0", err, d_valid);
    end
    do_read(4'd3, q, v, pe);
    n_checks++;
    if (q !== 32'hDE22BE44 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_merge: d_out=%h d_valid=%b, want de22be44 1", q, v);
    end
    tick();
    n_checks++;
    if (d_valid !== 1'b0 || d_out !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL read_hold: d_out=%h d_valid=%b, want de22be44 0", d_out, d_valid);
    end
  endtask

  task automatic test_collision();
    logic [31:0] q; logic v, pe;
    cs = 1; rd = 1; wr = 1; addr = 4'd5; data = 32'hFFFFFFFF; be = 4'hF;
    tick();
    set_idle();
    n_checks++;
    if (err !== 1'b1 || d_valid !== 1'b0 || d_out !== 32'hDE22BE44) begin
      n_fail++;
      $display("FAIL collision: err=%b d_valid=%b d_out=%h, want 1 0 de22be44",
               err, d_valid, d_out);
    end
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_pulse: err=%b one cycle later, want 0", err);
    end
    do_read(4'd5, q, v, pe);
    n_checks++;
    if (q !== 32'h0 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_no_write: d_out=%h d_valid=%b, want 00000000 1", q, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q; logic v, pe;
    logic [31:0] exp [3];
    exp[0] = 32'hA1B2C3D4; exp[1] = 32'h0F0F0F0F; exp[2] = 32'h12345678;
    for (int i = 0; i < 3; i++) do_write(i[3:0] + 4'd8, exp[i], 4'hF, 1'b0);
    // Write immediately followed by read of the same word.
    do_write(4'd12, 32'hCAFEF00D, 4'hF, 1'b0);
    do_read(4'd12, q, v, pe);
    n_checks++;
    if (q !== 32'hCAFEF00D || v !== 1'b1) begin
      n_fail++;
      $display("FAIL write_then_read: d_out=%h d_valid=%b, want cafef00d 1", q, v);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(i[3:0] + 4'd8, q, v, pe);
      n_checks++;
      if (q !== exp[i] || v !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: d_out=%h d_valid=%b, want %h 1", i, q, v, exp[i]);
      end
    end
    tick();
    n_checks++;
    if (d_valid !== 1'b0 || d_out !== exp[2]) begin
      n_fail++;
      $display("FAIL b2b_end: d_out=%h d_valid=%b, want %h 0", d_out, d_valid, exp[2]);
    end
  endtask

  task automatic test_parity();
    logic [31:0] q; logic v, pe;
    logic exp_pe;
`ifdef SP_RAM_PARITY_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    do_write(4'd7, 32'h000000FF, 4'hF, 1'b1);
    do_read(4'd7, q, v, pe);
    n_checks++;
    if (q !== 32'h000000FF || v !== 1'b1 || pe !== exp_pe) begin
      n_fail++;
      $display("FAIL parity_inject: d_out=%h d_valid=%b par_err=%b, want 000000ff 1 %b",
               q, v, pe, exp_pe);
    end
    do_write(4'd7, 32'h000000FF, 4'hF, 1'b0);
    do_read(4'd7, q, v, pe);
    n_checks++;
    if (q !== 32'h000000FF || v !== 1'b1 || pe !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clean: d_out=%h d_valid=%b par_err=%b, want 000000ff 1 0",
               q, v, pe);
    end
  endtask

  task automatic test_init_ignore();
    logic [31:0] q; logic v, pe;
    int n;
    int bad = 0;
    rst = 1; tick(); rst = 0;
    tick();
    for (int c = 2; c < 14; c++) begin
      cs = 1; addr = (c < 10) ? 4'd15 : 4'd0; data = 32'hA5A5A5A5; be = 4'hF;
      rd = (c >= 6 && c < 8) || c >= 12;
      wr = !(c >= 12);
      tick();
      if (d_valid !== 1'b0 || err !== 1'b0 || ready !== 1'b0) bad++;
    end
    set_idle();
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL init_ignores_ports: %0d cycles with d_valid/err/ready set, want 0", bad);
    end
    wait_ready(n);
    do_read(4'd15, q, v, pe);
    n_checks++;
    if (q !== 32'h0 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL init_write15: d_out=%h d_valid=%b, want 00000000 1", q, v);
    end
    do_read(4'd0, q, v, pe);
    n_checks++;
    if (q !== 32'h0 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL init_write0: d_out=%h d_valid=%b, want 00000000 1", q, v);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q; logic v, pe;
    int n;
    rst = 1; tick(); rst = 0;
    repeat (8) tick();
    rst = 1; tick(); rst = 0;
    wait_ready(n);
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL midinit_restart: ready after %0d cycles, want 16", n);
    end
    do_write(4'd3, 32'h55AA55AA, 4'hF, 1'b0);
    do_read(4'd3, q, v, pe);
    n_checks++;
    if (q !== 32'h55AA55AA || v !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_read: d_out=%h d_valid=%b, want 55aa55aa 1", q, v);
    end
    cs = 1; rd = 1; addr = 4'd3;
    #2 rst = 1;
    #1;
    n_checks++;
    if (d_out !== 32'h0 || d_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: d_out=%h d_valid=%b ready=%b, want 0 0 0",
               d_out, d_valid, ready);
    end
    tick();
    n_checks++;
    if (d_valid !== 1'b0 || d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL read_in_reset: d_out=%h d_valid=%b, want 0 0", d_out, d_valid);
    end
    rst = 0;
    set_idle();
    wait_ready(n);
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL idle_restart: ready after %0d cycles, want 16", n);
    end
    do_read(4'd3, q, v, pe);
    n_checks++;
    if (q !== 32'h0 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL reclear: d_out=%h d_valid=%b, want 00000000 1", q, v);
    end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_parity();
    test_init_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_be.md
SP_RAM_BE -- requirements
Module: sp_ram_be

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port cs  input  1  chip select; no access SHALL occur when low.
REQ-006 Port rd  input  1  read request.
REQ-007 Port wr  input  1  write request.
REQ-008 Port addr  input  ADDR_W  word address.
REQ-009 Port data  input  DATA_W  write data; input only, never driven by the block.
REQ-010 Port be  input  DATA_W/8  byte write enables; bit i covers data[8i+7:8i].
REQ-011 Port par_inj  input  1  parity-inject test hook; see Configuration.
REQ-012 Port d_out  output  DATA_W  registered read data.
REQ-013 Port d_valid  output  1  one-cycle pulse; d_out holds new read data.
REQ-014 Port ready  output  1  high when the block accepts requests.
REQ-015 Port err  output  1  one-cycle pulse on a rd/wr collision.
REQ-016 Port par_err  output  1  one-cycle pulse, read parity mismatch.

Function
REQ-017 Two-state FSM: INIT and IDLE; ready SHALL be 1 only in IDLE.
REQ-018 INIT: an ADDR_W counter SHALL write all-zero data (all bytes) to addresses 0..DEPTH-1, one per cycle, ascending.
REQ-019 INIT SHALL last exactly DEPTH cycles; after the word at DEPTH-1 is cleared, the FSM SHALL enter IDLE and ready SHALL rise; the counter SHALL NOT wrap and re-clear.
REQ-020 In INIT, cs/rd/wr SHALL be ignored: no memory change from the ports, no d_valid, no err.
REQ-021 Write: IDLE and cs&wr&!rd at a clock edge SHALL update only the bytes of mem[addr] whose be bit is 1; be=0 SHALL leave memory unchanged with no err.
REQ-022 Read: IDLE and cs&rd&!wr at edge N SHALL load d_out with mem[addr] and pulse d_valid for the cycle after edge N (latency 1).
REQ-023 A read SHALL return the contents before any same-edge write; back-to-back write then read of the same address SHALL return the new data.
REQ-024 d_out SHALL hold its last value when no read occurs.
REQ-025 Collision: IDLE and cs&rd&wr SHALL perform no access and SHALL pulse err for one cycle; d_valid SHALL stay 0.
REQ-026 Back-to-back reads SHALL be accepted every cycle, with d_valid high continuously.

Reset
REQ-027 rst high SHALL immediately force d_out=0, d_valid=0, err=0, par_err=0, ready=0, counter=0, FSM=INIT.
REQ-028 Reset asserted mid-INIT or mid-IDLE SHALL restart the full DEPTH-cycle clear on deassertion; an in-flight read SHALL produce no d_valid.

Configuration
REQ-029 Macro SP_RAM_PARITY_EN defined: one even-parity bit SHALL be stored per byte, written with that byte; INIT stores parity 0.
REQ-030 With SP_RAM_PARITY_EN: par_inj=1 during a write SHALL store the inverted parity of each written byte.
REQ-031 With SP_RAM_PARITY_EN: on a read, any byte parity mismatch SHALL pulse par_err in the same cycle as d_valid; d_out SHALL still carry the stored data.
REQ-032 Without SP_RAM_PARITY_EN: no parity storage; par_inj SHALL be ignored and par_err SHALL be tied 0; all other behaviour identical.

Verification (DATA_W=32, ADDR_W=4)
REQ-033 Reset released -> ready=0 for exactly 16 cycles, then 1; read of every address returns 0x00000000.
REQ-034 Write 0xDEADBEEF be=4'hF addr 3, then write 0x11223344 be=4'b0101 addr 3, then read addr 3 -> d_out=0xDE22BE44, with d_valid one cycle after the read edge.
REQ-035 cs=1 rd=1 wr=1 addr 5 data 0xFFFFFFFF -> err pulse of one cycle, d_valid=0, next read of addr 5 returns 0.
REQ-036 Requests issued during INIT (write 0xA5A5A5A5 addr 15 at cycle 2) -> after ready, read addr 15 returns 0.
REQ-037 rst pulsed at cycle 8 of INIT -> ready rises 16 cycles after deassertion; rst during a read -> no d_valid, d_out=0.
REQ-038 SP_RAM_PARITY_EN: write 0x000000FF addr 7 with par_inj=1, read addr 7 -> d_out=0x000000FF, par_err=1 with d_valid; same write with par_inj=0 -> par_err=0.
